uart_tx_buffer: RTL and testbench

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

---
 rtl/uart_defs.sv | 33 +++
 rtl/sync_fifo.sv | 84 ++++++++
 rtl/uart_tx_buffer.sv | 105 ++++++++++
 tb/tb_uart_tx_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// ============================================================================
// Module      : uart_defs (package)
// Description : Shared sizing, FSM state encodings and start-timeout length
//               for the UART transmit buffer and its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_defs;

    // Default FIFO depth in bytes (power of two, 4..64)
    localparam int DEPTH_DEFAULT  = 16;

    // Byte width; the UART path is byte oriented
    localparam int DATA_W_DEFAULT = 8;

    // Cycles spent in WAIT_START before transmit is re-pulsed
    localparam int START_TIMEOUT  = 4;

    // Width of the start-timeout counter
    localparam int TIMER_W        = 3;

    // Transmit sequencer states
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD       = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Circular-buffer byte FIFO with wrapping pointers, occupancy
//               count and a registered ready flag that blocks writes when full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo
    import uart_defs::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              ready,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_next;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && ready;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Next occupancy: simultaneous push and pop cancel out
    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; ready tracks !full after each edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            ready <= (count_next != CW'(DEPTH));
        end
    end

    // Full is only consumed through the registered ready flag
    logic unused_full;
    assign unused_full = full;

endmodule

`default_nettype wire

// File: rtl/uart_tx_buffer.sv
// ============================================================================
// Module      : uart_tx_buffer
// Description : Byte FIFO between a producer and a UART transmitter. Pops one
//               byte at a time into tx_byte, pulses transmit, and retries the
//               pulse if the UART never reports busy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_buffer
    import uart_defs::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    output logic                     transmit,
    output logic [DATA_W-1:0]        tx_byte,
    input  logic                     is_transmitting,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    tx_state_t          state;
    logic [TIMER_W-1:0] timer;
    logic               fifo_empty;
    logic [DATA_W-1:0]  fifo_head;
    logic               pop;

    // Pop only on the IDLE->LOAD transition, so a retry never consumes another byte
    assign pop = (state == IDLE) && !fifo_empty && !is_transmitting;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_valid),
        .push_data (wr_data),
        .ready     (wr_ready),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (count)
    );

    // Transmit sequencer: load byte, pulse start, wait for UART busy, wait for frame end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            transmit <= 1'b0;
            tx_byte  <= '0;
            timer    <= '0;
        end else begin
            transmit <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= LOAD;
                        tx_byte  <= fifo_head;
                        transmit <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= WAIT_START;
                    timer <= '0;
                end
                WAIT_START: begin
                    if (is_transmitting) begin
                        state <= WAIT_DONE;
                    end else if (timer == TIMER_W'(START_TIMEOUT - 1)) begin
                        // UART missed the pulse: resend the same byte
                        state    <= LOAD;
                        transmit <= 1'b1;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!is_transmitting) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Flag a write offered while the buffer is not ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else begin
            overflow <= wr_valid && !wr_ready;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
// ============================================================================
// Module      : tb_uart_tx_buffer
// Description : Directed/randomized bench for uart_tx_buffer with a simple
//               UART model and a queue-based expected byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_buffer;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       is_transmitting;
    logic [4:0] count;
    logic       overflow;

    // UART model controls
    logic       uart_auto = 1'b0;
    logic       manual_busy = 1'b0;
    logic       auto_busy = 1'b0;
    int         busy_cnt = 0;

    logic [7:0] line_q[$];
    logic [7:0] exp_q[$];
    int         tx_pulses = 0;
    int         ovf_pulses = 0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    assign is_transmitting = uart_auto ? auto_busy : manual_busy;

    uart_tx_buffer #(
        .DEPTH  (DEPTH),
        .DATA_W (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .wr_valid        (wr_valid),
        .wr_data         (wr_data),
        .wr_ready        (wr_ready),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .is_transmitting (is_transmitting),
        .count           (count),
        .overflow        (overflow)
    );

    // UART model: on a start pulse, capture the byte and stay busy for a random frame length
    always @(posedge clk) begin
        if (busy_cnt != 0) begin
            busy_cnt  <= busy_cnt - 1;
            auto_busy <= (busy_cnt != 1);
        end else if (uart_auto && transmit) begin
            busy_cnt  <= $urandom_range(4, 8);
            auto_busy <= 1'b1;
            line_q.push_back(tx_byte);
        end else begin
            auto_busy <= 1'b0;
        end
    end

    // Pulse counters for transmit and overflow
    always @(posedge clk) begin
        if (transmit === 1'b1) tx_pulses++;
        if (overflow === 1'b1) ovf_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Let the UART model run until every expected byte is on the line, then compare order
    task automatic drain(input string tag);
        int cyc;
        int n;
        int idx;
        cyc = 0;
        n = exp_q.size();
        manual_busy = 1'b0;
        uart_auto = 1'b1;
        while ((line_q.size() < n || is_transmitting || count != 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("%s_drain_in_time", tag), (cyc < 3000), 1);
        repeat (3) @(negedge clk);
        chk($sformatf("%s_line_len", tag), line_q.size(), n);
        idx = 0;
        while (exp_q.size() > 0 && line_q.size() > 0) begin
            chk($sformatf("%s_byte_%0d", tag, idx), line_q.pop_front(), exp_q.pop_front());
            idx++;
        end
        exp_q.delete();
        line_q.delete();
        chk($sformatf("%s_count_zero", tag), count, 0);
    endtask

    // Hard stop if something hangs
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] head;
        logic       model_ready;
        int         ovf0;
        int         snap;
        int         cyc;

        // ---------------- reset state ----------------
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_transmit", transmit, 0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_overflow", overflow, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_first_edge", wr_ready, 1);

        // ---------------- single byte ----------------
        uart_auto = 1'b1;
        wr_valid = 1'b1;
        wr_data = 8'h41;
        exp_q.push_back(8'h41);
        @(negedge clk);
        wr_valid = 1'b0;
        chk("single_n1_transmit", transmit, 0);
        chk("single_n1_count", count, 1);
        @(negedge clk);
        chk("single_n2_transmit", transmit, 1);
        chk("single_n2_tx_byte", tx_byte, 8'h41);
        chk("single_n2_count", count, 0);
        drain("single");

        // ---------------- burst of 20 into depth 16 ----------------
        uart_auto = 1'b0;
        manual_busy = 1'b1;
        @(negedge clk);
        ovf0 = ovf_pulses;
        for (int i = 0; i < 20; i++) begin
            model_ready = (exp_q.size() < DEPTH);
            wr_valid = 1'b1;
            wr_data = i[7:0];
            chk($sformatf("burst_ready_%0d", i), wr_ready, model_ready);
            if (model_ready) exp_q.push_back(i[7:0]);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("burst_count", count, exp_q.size());
        chk("burst_overflow_pulses", ovf_pulses - ovf0, 20 - exp_q.size());
        drain("burst");

        // ---------------- wrap-around: 3 rounds of 12 ----------------
        for (int r = 0; r < 3; r++) begin
            uart_auto = 1'b0;
            manual_busy = 1'b1;
            for (int i = 0; i < 12; i++) begin
                b = 8'($urandom);
                wr_valid = 1'b1;
                wr_data = b;
                exp_q.push_back(b);
                @(negedge clk);
            end
            wr_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("wrap%0d_count", r), count, 12);
            drain($sformatf("wrap%0d", r));
        end

        // ---------------- simultaneous push/pop at count 5 ----------------
        uart_auto = 1'b0;
        manual_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            wr_valid = 1'b1;
            wr_data = b;
            exp_q.push_back(b);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        @(negedge clk);
        chk("simul_pre_count", count, 5);
        head = exp_q[0];
        b = 8'($urandom);
        manual_busy = 1'b0;
        wr_valid = 1'b1;
        wr_data = b;
        exp_q.push_back(b);
        @(negedge clk);
        wr_valid = 1'b0;
        chk("simul_count", count, 5);
        chk("simul_transmit", transmit, 1);
        chk("simul_tx_byte", tx_byte, head);

        // ---------------- start timeout (UART never goes busy) ----------------
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("timeout_quiet_%0d", k), transmit, 0);
        end
        @(negedge clk);
        chk("timeout_retransmit", transmit, 1);
        chk("timeout_tx_byte", tx_byte, head);
        chk("timeout_count", count, 5);

        // ---------------- reset mid-frame with 3 buffered ----------------
        uart_auto = 1'b1;
        cyc = 0;
        while (!(count == 3 && is_transmitting) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("midframe_reached", (cyc < 500), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        uart_auto = 1'b0;
        manual_busy = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_count", count, 0);
        chk("midrst_wr_ready", wr_ready, 0);
        chk("midrst_transmit", transmit, 0);
        chk("midrst_tx_byte", tx_byte, 8'h00);
        exp_q.delete();
        line_q.delete();
        snap = tx_pulses;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_release_ready", wr_ready, 1);
        chk("midrst_release_count", count, 0);
        repeat (20) @(negedge clk);
        chk("midrst_no_transmit", tx_pulses - snap, 0);

        // ---------------- buffer usable after reset ----------------
        b = 8'($urandom);
        wr_valid = 1'b1;
        wr_data = b;
        exp_q.push_back(b);
        @(negedge clk);
        wr_valid = 1'b0;
        drain("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
